// File: rtl/memory_io_ctrl_pkg.sv
// rtl/memory_io_ctrl_pkg.sv - default sizes and I/O offset map for memory_io_ctrl
package memory_io_ctrl_pkg;

    localparam int DEFAULT_WORD_SIZE      = 16;
    localparam int DEFAULT_ADDR_SIZE      = 14;
    localparam int DEFAULT_OUT_FIFO_DEPTH = 4;
    localparam int DEFAULT_NUM_IN_PORTS   = 2;

    localparam int IO_OUT_OFFSET     = 0;
    localparam int IO_STATUS_OFFSET  = 1;
    localparam int IO_IN_BASE_OFFSET = 2;

endpackage

// File: rtl/memory_io_ctrl_if.sv
// rtl/memory_io_ctrl_if.sv - cpu data bus (addressM/outM/writeM/inM) between cpu and memory_io_ctrl
interface memory_io_ctrl_if
    import memory_io_ctrl_pkg::*;
#(
    parameter int WordSize = DEFAULT_WORD_SIZE,
    parameter int AddrSize = DEFAULT_ADDR_SIZE
);
    logic [AddrSize:0]   addressM;
    logic [WordSize-1:0] dataW;
    logic                writeM;
    logic                readM;
    logic [WordSize-1:0] dataR;
    logic                stall;

    modport master (output addressM, dataW, writeM, readM, input dataR, stall);
    modport slave  (input addressM, dataW, writeM, readM, output dataR, stall);
endinterface

// File: rtl/memory_io_ctrl_word_fifo.sv
// rtl/memory_io_ctrl_word_fifo.sv - power-of-two word FIFO with occupancy count
module word_fifo #(
    parameter int WordSize = 16,
    parameter int Depth    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WordSize-1:0]      wdata_i,
    output logic [WordSize-1:0]      rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);
    localparam int PtrW = $clog2(Depth);

    logic [WordSize-1:0] mem [Depth];
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]       count_q, count_d;

    // Caller only pushes when not full or popping in the same cycle.
    always_comb begin
        wr_ptr_d = push_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_i  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem[rd_ptr_q];
    assign full_o  = (count_q == (PtrW+1)'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
endmodule

// File: rtl/memory_io_ctrl.sv
// rtl/memory_io_ctrl.sv - data RAM plus I/O space (out FIFO, input ports, status); IO_OVERRUN_CNT_EN adds overrun counters
module memory_io_ctrl
    import memory_io_ctrl_pkg::*;
#(
    parameter int WordSize     = DEFAULT_WORD_SIZE,
    parameter int AddrSize     = DEFAULT_ADDR_SIZE,
    parameter int OutFifoDepth = DEFAULT_OUT_FIFO_DEPTH,
    parameter int NumInPorts   = DEFAULT_NUM_IN_PORTS
) (
    input  logic                           clk,
    input  logic                           reset,
    memory_io_ctrl_if.slave                bus,
    input  logic [NumInPorts*WordSize-1:0] in_data,
    input  logic [NumInPorts-1:0]          in_valid,
    output logic [WordSize-1:0]            out_data,
    output logic                           out_valid,
    input  logic                           out_ready
);
    localparam int CntW = $clog2(OutFifoDepth) + 1;

    logic                is_io;
    logic [AddrSize-1:0] off;
    logic                pop, push, wr_out, fifo_full, fifo_empty;
    logic [CntW-1:0]     fifo_count;

    logic [WordSize-1:0] ram [2**AddrSize];

    logic [NumInPorts-1:0] flag_q, flag_d, rd_clr;
    logic [WordSize-1:0]   port_q [NumInPorts];
    logic [WordSize-1:0]   port_d [NumInPorts];
    logic [WordSize-1:0]   status;

    assign is_io  = bus.addressM[AddrSize];
    assign off    = bus.addressM[AddrSize-1:0];
    assign pop    = out_valid && out_ready;
    assign wr_out = bus.writeM && is_io && (off == AddrSize'(IO_OUT_OFFSET));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push      = wr_out && (!fifo_full || pop);
    assign bus.stall = wr_out && fifo_full && !pop;
    assign out_valid = !fifo_empty;

    word_fifo #(.WordSize(WordSize), .Depth(OutFifoDepth)) u_out_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (bus.dataW),
        .rdata_o (out_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (bus.writeM && !is_io) ram[off] <= bus.dataW;
    end

    // Capture has priority over the read-clear of the same port.
    always_comb begin
        for (int i = 0; i < NumInPorts; i++) begin
            rd_clr[i] = bus.readM && is_io && (off == AddrSize'(IO_IN_BASE_OFFSET + i));
            flag_d[i] = in_valid[i] | (flag_q[i] & ~rd_clr[i]);
            port_d[i] = in_valid[i] ? in_data[i*WordSize +: WordSize] : port_q[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flag_q <= '0;
            for (int i = 0; i < NumInPorts; i++) port_q[i] <= '0;
        end else begin
            flag_q <= flag_d;
            for (int i = 0; i < NumInPorts; i++) port_q[i] <= port_d[i];
        end
    end

`ifdef IO_OVERRUN_CNT_EN
    logic [WordSize-1:0]   cnt_q [NumInPorts];
    logic [WordSize-1:0]   cnt_d [NumInPorts];
    logic [NumInPorts-1:0] cnt_clr;

    // A read-clear of the counter wins over a same-cycle overrun.
    always_comb begin
        for (int i = 0; i < NumInPorts; i++) begin
            cnt_clr[i] = bus.readM && is_io
                         && (off == AddrSize'(IO_IN_BASE_OFFSET + NumInPorts + i));
            cnt_d[i]   = cnt_q[i];
            if (cnt_clr[i])
                cnt_d[i] = '0;
            else if (in_valid[i] && flag_q[i] && !rd_clr[i] && (cnt_q[i] != '1))
                cnt_d[i] = cnt_q[i] + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NumInPorts; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NumInPorts; i++) cnt_q[i] <= cnt_d[i];
        end
    end
`endif

    always_comb begin
        status    = '0;
        status[0] = fifo_full;
        status[1] = fifo_empty;
        for (int i = 0; i < NumInPorts; i++) status[2+i] = flag_q[i];

        bus.dataR = '0;
        if (!is_io) begin
            bus.dataR = ram[off];
        end else if (off == AddrSize'(IO_OUT_OFFSET)) begin
            bus.dataR = WordSize'(fifo_count);
        end else if (off == AddrSize'(IO_STATUS_OFFSET)) begin
            bus.dataR = status;
        end else begin
            for (int i = 0; i < NumInPorts; i++) begin
                if (off == AddrSize'(IO_IN_BASE_OFFSET + i)) bus.dataR = port_q[i];
`ifdef IO_OVERRUN_CNT_EN
                if (off == AddrSize'(IO_IN_BASE_OFFSET + NumInPorts + i)) bus.dataR = cnt_q[i];
`endif
            end
        end
    end
endmodule

// File: tb/tb_memory_io_ctrl.sv
// tb/tb_memory_io_ctrl.sv - scoreboard bench for memory_io_ctrl
module tb_memory_io_ctrl;
    localparam logic [14:0] A_OUT    = 15'h4000;
    localparam logic [14:0] A_STATUS = 15'h4001;
    localparam logic [14:0] A_IN0    = 15'h4002;
    localparam logic [14:0] A_IN1    = 15'h4003;
    localparam logic [14:0] A_CNT0   = 15'h4004;
    localparam logic [14:0] A_NONE   = 15'h4010;
`ifdef IO_OVERRUN_CNT_EN
    localparam logic [15:0] EXP_CNT = 16'd2;
`else
    localparam logic [15:0] EXP_CNT = 16'd0;
`endif

    typedef struct {
        int          kind;
        logic [15:0] exp;
        string       name;
    } chk_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic [1:0]  in_valid;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    chk_t        chk_q[$];
    logic [15:0] out_q[$];

    memory_io_ctrl_if #(.WordSize(16), .AddrSize(14)) bus_if ();

    memory_io_ctrl #(.WordSize(16), .AddrSize(14), .OutFifoDepth(4), .NumInPorts(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_if.slave),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Monitor: compares queued expectations and the output stream on the falling edge.
    always @(negedge clk) begin
        chk_t        c;
        logic [15:0] act;
        logic [15:0] e;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            case (c.kind)
                0:       act = bus_if.dataR;
                1:       act = {15'b0, bus_if.stall};
                2:       act = {15'b0, out_valid};
                default: act = 16'(out_q.size());
            endcase
            checks++;
            if (act !== c.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
            end
        end
        if (out_valid && out_ready) begin
            checks++;
            if (out_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got %h expected no word", out_data);
            end else begin
                e = out_q.pop_front();
                if (out_data !== e) begin
                    errors++;
                    $display("FAIL out_data: got %h expected %h", out_data, e);
                end
            end
        end
    end

    task automatic expect_val(input int kind, input logic [15:0] exp, input string name);
        chk_q.push_back('{kind, exp, name});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [14:0] a, input logic [15:0] d);
        bus_if.addressM = a;
        bus_if.dataW    = d;
        bus_if.writeM   = 1'b1;
        tick();
        bus_if.writeM   = 1'b0;
    endtask

    task automatic rd(input logic [14:0] a, input logic [15:0] exp, input string name);
        bus_if.addressM = a;
        expect_val(0, exp, name);
        tick();
    endtask

    task automatic rd_consume(input logic [14:0] a, input logic [15:0] exp, input string name);
        bus_if.readM = 1'b1;
        rd(a, exp, name);
        bus_if.readM = 1'b0;
    endtask

    initial begin
        reset           = 1'b0;
        in_data         = '0;
        in_valid        = '0;
        out_ready       = 1'b0;
        bus_if.addressM = A_OUT;
        bus_if.dataW    = 16'h0;
        bus_if.writeM   = 1'b1;
        bus_if.readM    = 1'b0;
        tick();

        expect_val(2, 16'h0, "rst_out_valid");
        expect_val(1, 16'h0, "rst_stall");
        expect_val(0, 16'h0, "rst_count");
        tick();
        bus_if.writeM = 1'b0;
        rd(A_STATUS, 16'h0002, "rst_status");
        reset = 1'b1;
        tick();

        wr(15'd5, 16'h1234);
        wr(15'd6, 16'hBEEF);
        rd(15'd5, 16'h1234, "ram_addr5");
        rd(15'd6, 16'hBEEF, "ram_addr6");
        rd(A_NONE, 16'h0000, "unmapped_io");

        for (int i = 1; i <= 4; i++) begin
            wr(A_OUT, 16'(i));
            out_q.push_back(16'(i));
        end
        rd(A_STATUS, 16'h0001, "status_full");
        rd(A_OUT, 16'd4, "count_full");
        bus_if.addressM = A_OUT;
        bus_if.dataW    = 16'd5;
        bus_if.writeM   = 1'b1;
        expect_val(1, 16'h1, "stall_when_full");
        tick();
        bus_if.writeM = 1'b0;
        rd(A_OUT, 16'd4, "count_after_drop");
        out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;
        expect_val(2, 16'h0, "drained_out_valid");
        rd(A_STATUS, 16'h0002, "status_empty");

        for (int i = 0; i < 4; i++) begin
            wr(A_OUT, 16'h0010 + 16'(i));
            out_q.push_back(16'h0010 + 16'(i));
        end
        out_ready       = 1'b1;
        bus_if.addressM = A_OUT;
        bus_if.dataW    = 16'd9;
        bus_if.writeM   = 1'b1;
        out_q.push_back(16'd9);
        expect_val(1, 16'h0, "no_stall_push_pop");
        tick();
        bus_if.writeM = 1'b0;
        out_ready     = 1'b0;
        rd(A_OUT, 16'd4, "count_push_pop");
        out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;
        expect_val(2, 16'h0, "drained2_out_valid");

        in_data  = 32'h00AB_0000;
        in_valid = 2'b10;
        tick();
        in_valid = 2'b00;
        rd(A_STATUS, 16'h000A, "status_flag1");
        rd(A_IN1, 16'h00AB, "in1_value");
        wr(A_STATUS, 16'hFFFF);
        wr(A_IN1, 16'h5555);
        rd_consume(A_IN1, 16'h00AB, "in1_consume");
        rd(A_STATUS, 16'h0002, "status_flag1_cleared");
        in_data  = 32'h00CD_0000;
        in_valid = 2'b10;
        rd_consume(A_IN1, 16'h00AB, "in1_consume_capture");
        in_valid = 2'b00;
        rd(A_STATUS, 16'h000A, "status_capture_wins");
        rd(A_IN1, 16'h00CD, "in1_new_value");

        in_valid = 2'b01;
        for (int i = 1; i <= 3; i++) begin
            in_data = 32'(i);
            tick();
        end
        in_valid = 2'b00;
        rd(A_IN0, 16'h0003, "in0_last_capture");
        rd(A_CNT0, EXP_CNT, "cnt0_value");
        rd_consume(A_CNT0, EXP_CNT, "cnt0_consume");
        rd(A_CNT0, 16'h0000, "cnt0_cleared");

        for (int i = 0; i < 3; i++) wr(A_OUT, 16'h0070 + 16'(i));
        rd(A_OUT, 16'd3, "count_before_reset");
        rd(A_STATUS, 16'h000C, "status_before_reset");
        bus_if.addressM = A_STATUS;
        reset = 1'b0;
        expect_val(2, 16'h0, "async_rst_out_valid");
        expect_val(0, 16'h0002, "async_rst_status");
        tick();
        bus_if.addressM = A_OUT;
        bus_if.dataW    = 16'd5;
        bus_if.writeM   = 1'b1;
        expect_val(1, 16'h0, "async_rst_stall");
        tick();
        bus_if.writeM = 1'b0;
        reset = 1'b1;
        rd(15'd5, 16'h1234, "ram_kept_over_reset");
        rd(A_STATUS, 16'h0002, "status_after_reset");
        rd(A_OUT, 16'd0, "count_after_reset");
        rd(A_CNT0, 16'h0000, "cnt0_after_reset");

        expect_val(3, 16'h0, "out_queue_drained");
        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/memory_io_ctrl.md
Name: memory_io_ctrl

Overview:
Parametrised data-memory and memory-mapped I/O controller behind the cpu's addressM/outM/writeM/inM bus.
- addressM MSB selects RAM (0) or I/O space (1).
- I/O space holds an output stream FIFO with valid/ready handshake, NumInPorts latched input ports with sticky valid flags, and a status register.
- Successor to the single-word register/RAM used under the cpu: generalised in width, depth and port count, and adds buffering, back-pressure and read side effects.

Parameters:
WordSize, 16, data width (matches `DefaultWordSize)
AddrSize, 14, RAM address bits; RAM holds 2**AddrSize words; bus address is AddrSize+1 bits
OutFifoDepth, 4, output FIFO entries; power of two, >=2
NumInPorts, 2, number of input ports, 1..8

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-low reset
addressM  input  AddrSize+1  cpu data address
dataW  input  WordSize  cpu write data (cpu outM)
writeM  input  1  cpu write strobe
readM  input  1  cpu read-consume strobe; triggers read side effects
dataR  output  WordSize  read data to cpu inM; combinational from addressM
stall  output  1  write cannot complete this cycle; cpu holds bus
in_data  input  NumInPorts*WordSize  input port data, port i at [i*WordSize +: WordSize]
in_valid  input  NumInPorts  one-cycle capture strobe per port
out_data  output  WordSize  FIFO head
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer accepts head

Behaviour:
- reset low (async): FIFO pointers/count=0, all in_flag=0, port registers=0, overrun counters=0. Hence out_valid=0, stall=0. RAM contents not reset.
- RAM (addressM[AddrSize]=0):
  - read combinational: dataR=ram[addressM[AddrSize-1:0]], zero latency.
  - write on rising clk when writeM=1; never stalls.
- I/O offset = addressM[AddrSize-1:0].
  - 0 OUT: write pushes dataW. Read returns FIFO count, zero-extended.
  - 1 STATUS: read only. bit0=full, bit1=empty, bits[2+i]=in_flag[i]; rest 0.
  - 2..1+NumInPorts IN[i]: read returns port register i. readM=1 clears in_flag[i] at the next edge.
  - 2+NumInPorts: see Optional Feature.
  - All other offsets read 0; writes ignored.
- FIFO:
  - pop when out_valid&&out_ready.
  - push when writeM to OUT and (!full || pop same cycle).
  - stall=writeM && addr==OUT && full && !(out_valid&&out_ready); the dropped write is not stored.
  - Simultaneous push+pop: count unchanged; data order preserved.
  - Pointers wrap modulo OutFifoDepth.
- Input ports:
  - in_valid[i]=1: port register i<=in_data slice, in_flag[i]<=1 at the edge.
  - Capture and read-clear in the same cycle: capture wins, flag stays 1.
  - Writes to IN/STATUS ignored.
- writeM and readM both 1 at an I/O address: write effect and read side effect both apply.

Optional Feature:
IO_OVERRUN_CNT_EN
- Defined:
  - One saturating WordSize counter per port; increments when in_valid[i]=1 while in_flag[i]=1 and no clear that cycle.
  - Offset 2+NumInPorts+i reads counter i.
  - readM at that offset clears counter i next edge; a same-cycle increment is lost.
- Undefined: no counters; those offsets read 0.

Decomposition:
- Shared const.h: `DefaultWordSize, `DefaultAddrSize, new `DefaultOutFifoDepth, `DefaultNumInPorts, and I/O offset defines `IoOutOffset=0, `IoStatusOffset=1, `IoInBaseOffset=2.
- One sub-module, word_fifo (parameters WordSize, Depth): push/pop/full/empty/count, async active-low reset.
- Port registers, flags and counters stay in memory_io_ctrl.

Test Plan:
- RAM: write 16'h1234 to addr 5, then read addr 5 -> dataR=16'h1234 combinationally; addr 6 write does not disturb addr 5.
- FIFO: out_ready=0, write 1,2,3,4 to OUT -> STATUS bit0=1, count=4; 5th write -> stall=1 and 5 not stored. out_ready=1 -> out_data 1,2,3,4 in order; then empty, STATUS bit1=1.
- Full with out_ready=1: write 9 to OUT -> stall=0, count stays 4, 9 emerges last.
- Port 1: in_valid pulse with data 16'h00AB -> STATUS bit3=1, IN[1] reads 16'h00AB. readM on IN[1] -> bit3=0 next cycle. Capture and readM in the same cycle -> bit3 stays 1.
- Reset low mid-stream (FIFO count=3, flags set) -> immediately out_valid=0, STATUS=16'h0002, stall=0. Reset released -> RAM word at addr 5 unchanged.
- IO_OVERRUN_CNT_EN defined: three in_valid pulses on port 0 without read -> counter0 reads 2; readM -> 0 next cycle. Undefined: the same offset reads 0.
